// File: rtl/c499_clk_op_ff_pnr_pkg.sv
// c499_clk_op_ff_pnr_pkg
//   Shared definitions for the registered c499 SEC decoder:
//   - the registered input bundle (data, check bits, check enable)
//   - the 32x8 column table as one-hot/pair selects
//   - col_mask(): the weight-3 syndrome column of data bit k
//
//   Port numbering: data bit d[k] is primary input N(1+4k), check bit c[j]
//   is N(129+j), the enable R is N137 and corrected bit k drives
//   Qout_N(724+k).
package c499_clk_op_ff_pnr_pkg;

    localparam int unsigned NUM_DATA  = 32;
    localparam int unsigned NUM_CHECK = 8;

    typedef struct packed {
        logic [NUM_DATA-1:0]  d;
        logic [NUM_CHECK-1:0] c;
        logic                 r;
    } c499_in_t;

    // Pair selects indexed by (k%16)/4. Lower half of the data word pairs
    // S4/S5 with S6/S7; upper half pairs S0/S1 with S2/S3.
    localparam logic [7:0] PAIR_LO [4] = '{8'h50, 8'h90, 8'h60, 8'hA0};
    localparam logic [7:0] PAIR_HI [4] = '{8'h05, 8'h09, 8'h06, 8'h0A};

    // One-hot select: S(k%4) for the lower half, S(4+k%4) for the upper half.
    function automatic logic [7:0] col_mask(input logic [4:0] k);
        logic [1:0] row;
        logic [1:0] grp;
        logic [7:0] m;
        row = k[1:0];
        grp = k[3:2];
        if (k[4]) begin
            m = (8'h10 << row) | PAIR_HI[grp];
        end else begin
            m = (8'h01 << row) | PAIR_LO[grp];
        end
        return m;
    endfunction

endpackage

// File: rtl/c499_sec_core.sv
// c499_sec_core
//   Purely combinational c499 single-error-correcting decoder.
//   Ports:
//     d_i [31:0]  data bits
//     c_i [7:0]   received check bits
//     r_i         check-bit enable
//     g_o [7:0]   gated check bits c & R
//     s_o [7:0]   syndrome
//     f_o [31:0]  flip mask (one-hot on an exact column match, else zero)
//     o_o [31:0]  corrected data d ^ f
module c499_sec_core
    import c499_clk_op_ff_pnr_pkg::*;
(
    input  logic [NUM_DATA-1:0]  d_i,
    input  logic [NUM_CHECK-1:0] c_i,
    input  logic                 r_i,
    output logic [NUM_CHECK-1:0] g_o,
    output logic [NUM_CHECK-1:0] s_o,
    output logic [NUM_DATA-1:0]  f_o,
    output logic [NUM_DATA-1:0]  o_o
);

    logic [NUM_CHECK-1:0] gate;
    logic [NUM_CHECK-1:0] syn;
    logic [NUM_DATA-1:0]  flip;

    // The syndrome is the gated check bits XORed with the column of every
    // set data bit; this reproduces the per-bit parity trees exactly.
    always_comb begin
        gate = c_i & {NUM_CHECK{r_i}};
        syn  = gate;
        flip = '0;
        for (int unsigned k = 0; k < NUM_DATA; k++) begin
            if (d_i[k]) begin
                syn = syn ^ col_mask(5'(k));
            end
        end
        for (int unsigned k = 0; k < NUM_DATA; k++) begin
            flip[k] = (syn == col_mask(5'(k)));
        end
    end

    assign g_o = gate;
    assign s_o = syn;
    assign f_o = flip;
    assign o_o = d_i ^ flip;

endmodule

// File: rtl/c499_clk_op_ff_pnr.sv
// c499_clk_op_ff_pnr
//   Two-stage registered wrapper around the c499 SEC decoder.
//   Ports:
//     clk                 rising-edge clock
//     N1..N125 (step 4)   data bits d[k] = N(1+4k)
//     N129..N136          check bits c[j]
//     N137                check-bit enable R
//     IN_N*               stage-1 registered copies of the inputs
//     Qout_N724..N755     stage-2 registered corrected data, bit k at 724+k
//     nn1..nn8            syndrome S0..S7
//     nn9..nn40           flip mask f0..f31
//     nn41..nn48          gated check bits c[j] & R
//     nn49                OR of the syndrome
//     reset_n             asynchronous active-low reset for every flop
//   Input sampled at edge t appears on IN_N*/nn* after t and on Qout after t+1.
module c499_clk_op_ff_pnr
    import c499_clk_op_ff_pnr_pkg::*;
(
    input  logic clk,
    input  logic N1, N5, N9, N13, N17, N21, N25, N29,
    input  logic N33, N37, N41, N45, N49, N53, N57, N61,
    input  logic N65, N69, N73, N77, N81, N85, N89, N93,
    input  logic N97, N101, N105, N109, N113, N117, N121, N125,
    input  logic N129, N130, N131, N132, N133, N134, N135, N136,
    input  logic N137,
    output logic IN_N1, IN_N5, IN_N9, IN_N13, IN_N17, IN_N21, IN_N25, IN_N29,
    output logic IN_N33, IN_N37, IN_N41, IN_N45, IN_N49, IN_N53, IN_N57, IN_N61,
    output logic IN_N65, IN_N69, IN_N73, IN_N77, IN_N81, IN_N85, IN_N89, IN_N93,
    output logic IN_N97, IN_N101, IN_N105, IN_N109, IN_N113, IN_N117, IN_N121, IN_N125,
    output logic IN_N129, IN_N130, IN_N131, IN_N132, IN_N133, IN_N134, IN_N135, IN_N136,
    output logic IN_N137,
    output logic Qout_N724, Qout_N725, Qout_N726, Qout_N727,
    output logic Qout_N728, Qout_N729, Qout_N730, Qout_N731,
    output logic Qout_N732, Qout_N733, Qout_N734, Qout_N735,
    output logic Qout_N736, Qout_N737, Qout_N738, Qout_N739,
    output logic Qout_N740, Qout_N741, Qout_N742, Qout_N743,
    output logic Qout_N744, Qout_N745, Qout_N746, Qout_N747,
    output logic Qout_N748, Qout_N749, Qout_N750, Qout_N751,
    output logic Qout_N752, Qout_N753, Qout_N754, Qout_N755,
    output logic nn1, nn2, nn3, nn4, nn5, nn6, nn7, nn8,
    output logic nn9, nn10, nn11, nn12, nn13, nn14, nn15, nn16,
    output logic nn17, nn18, nn19, nn20, nn21, nn22, nn23, nn24,
    output logic nn25, nn26, nn27, nn28, nn29, nn30, nn31, nn32,
    output logic nn33, nn34, nn35, nn36, nn37, nn38, nn39, nn40,
    output logic nn41, nn42, nn43, nn44, nn45, nn46, nn47, nn48,
    output logic nn49,
    input  logic reset_n
);

    c499_in_t             in_d, in_q;
    logic [NUM_DATA-1:0]  q_d, q_q;
    logic [NUM_CHECK-1:0] gate, syn;
    logic [NUM_DATA-1:0]  flip, corr;

    // Scalar inputs gathered into the stage-1 bundle.
    assign in_d.d = {N125, N121, N117, N113, N109, N105, N101, N97,
                     N93,  N89,  N85,  N81,  N77,  N73,  N69,  N65,
                     N61,  N57,  N53,  N49,  N45,  N41,  N37,  N33,
                     N29,  N25,  N21,  N17,  N13,  N9,   N5,   N1};
    assign in_d.c = {N136, N135, N134, N133, N132, N131, N130, N129};
    assign in_d.r = N137;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= '0;
            q_q  <= '0;
        end else begin
            in_q <= in_d;
            q_q  <= q_d;
        end
    end

    c499_sec_core u_core (
        .d_i (in_q.d),
        .c_i (in_q.c),
        .r_i (in_q.r),
        .g_o (gate),
        .s_o (syn),
        .f_o (flip),
        .o_o (corr)
    );

    assign q_d = corr;

    assign {IN_N125, IN_N121, IN_N117, IN_N113, IN_N109, IN_N105, IN_N101, IN_N97,
            IN_N93,  IN_N89,  IN_N85,  IN_N81,  IN_N77,  IN_N73,  IN_N69,  IN_N65,
            IN_N61,  IN_N57,  IN_N53,  IN_N49,  IN_N45,  IN_N41,  IN_N37,  IN_N33,
            IN_N29,  IN_N25,  IN_N21,  IN_N17,  IN_N13,  IN_N9,   IN_N5,   IN_N1} = in_q.d;
    assign {IN_N136, IN_N135, IN_N134, IN_N133, IN_N132, IN_N131, IN_N130, IN_N129} = in_q.c;
    assign IN_N137 = in_q.r;

    assign {Qout_N755, Qout_N754, Qout_N753, Qout_N752, Qout_N751, Qout_N750, Qout_N749, Qout_N748,
            Qout_N747, Qout_N746, Qout_N745, Qout_N744, Qout_N743, Qout_N742, Qout_N741, Qout_N740,
            Qout_N739, Qout_N738, Qout_N737, Qout_N736, Qout_N735, Qout_N734, Qout_N733, Qout_N732,
            Qout_N731, Qout_N730, Qout_N729, Qout_N728, Qout_N727, Qout_N726, Qout_N725, Qout_N724} = q_q;

    assign {nn8, nn7, nn6, nn5, nn4, nn3, nn2, nn1} = syn;
    assign {nn40, nn39, nn38, nn37, nn36, nn35, nn34, nn33,
            nn32, nn31, nn30, nn29, nn28, nn27, nn26, nn25,
            nn24, nn23, nn22, nn21, nn20, nn19, nn18, nn17,
            nn16, nn15, nn14, nn13, nn12, nn11, nn10, nn9} = flip;
    assign {nn48, nn47, nn46, nn45, nn44, nn43, nn42, nn41} = gate;
    assign nn49 = |syn;

endmodule

// File: tb/tb_c499_clk_op_ff_pnr.sv
module tb_c499_clk_op_ff_pnr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] td;
    logic [7:0]  tc;
    logic        tr;

    wire  [31:0] in_dw;
    wire  [7:0]  in_cw;
    wire         in_rw;
    wire  [31:0] qw;
    wire  [49:1] nnw;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference pipeline state.
    logic [31:0] m_d, m_q;
    logic [7:0]  m_c;
    logic        m_r;

    always #5 clk = ~clk;

    c499_clk_op_ff_pnr dut (
        .clk(clk),
        .N1(td[0]), .N5(td[1]), .N9(td[2]), .N13(td[3]), .N17(td[4]), .N21(td[5]), .N25(td[6]), .N29(td[7]),
        .N33(td[8]), .N37(td[9]), .N41(td[10]), .N45(td[11]), .N49(td[12]), .N53(td[13]), .N57(td[14]), .N61(td[15]),
        .N65(td[16]), .N69(td[17]), .N73(td[18]), .N77(td[19]), .N81(td[20]), .N85(td[21]), .N89(td[22]), .N93(td[23]),
        .N97(td[24]), .N101(td[25]), .N105(td[26]), .N109(td[27]), .N113(td[28]), .N117(td[29]), .N121(td[30]), .N125(td[31]),
        .N129(tc[0]), .N130(tc[1]), .N131(tc[2]), .N132(tc[3]), .N133(tc[4]), .N134(tc[5]), .N135(tc[6]), .N136(tc[7]),
        .N137(tr),
        .IN_N1(in_dw[0]), .IN_N5(in_dw[1]), .IN_N9(in_dw[2]), .IN_N13(in_dw[3]),
        .IN_N17(in_dw[4]), .IN_N21(in_dw[5]), .IN_N25(in_dw[6]), .IN_N29(in_dw[7]),
        .IN_N33(in_dw[8]), .IN_N37(in_dw[9]), .IN_N41(in_dw[10]), .IN_N45(in_dw[11]),
        .IN_N49(in_dw[12]), .IN_N53(in_dw[13]), .IN_N57(in_dw[14]), .IN_N61(in_dw[15]),
        .IN_N65(in_dw[16]), .IN_N69(in_dw[17]), .IN_N73(in_dw[18]), .IN_N77(in_dw[19]),
        .IN_N81(in_dw[20]), .IN_N85(in_dw[21]), .IN_N89(in_dw[22]), .IN_N93(in_dw[23]),
        .IN_N97(in_dw[24]), .IN_N101(in_dw[25]), .IN_N105(in_dw[26]), .IN_N109(in_dw[27]),
        .IN_N113(in_dw[28]), .IN_N117(in_dw[29]), .IN_N121(in_dw[30]), .IN_N125(in_dw[31]),
        .IN_N129(in_cw[0]), .IN_N130(in_cw[1]), .IN_N131(in_cw[2]), .IN_N132(in_cw[3]),
        .IN_N133(in_cw[4]), .IN_N134(in_cw[5]), .IN_N135(in_cw[6]), .IN_N136(in_cw[7]),
        .IN_N137(in_rw),
        .Qout_N724(qw[0]), .Qout_N725(qw[1]), .Qout_N726(qw[2]), .Qout_N727(qw[3]),
        .Qout_N728(qw[4]), .Qout_N729(qw[5]), .Qout_N730(qw[6]), .Qout_N731(qw[7]),
        .Qout_N732(qw[8]), .Qout_N733(qw[9]), .Qout_N734(qw[10]), .Qout_N735(qw[11]),
        .Qout_N736(qw[12]), .Qout_N737(qw[13]), .Qout_N738(qw[14]), .Qout_N739(qw[15]),
        .Qout_N740(qw[16]), .Qout_N741(qw[17]), .Qout_N742(qw[18]), .Qout_N743(qw[19]),
        .Qout_N744(qw[20]), .Qout_N745(qw[21]), .Qout_N746(qw[22]), .Qout_N747(qw[23]),
        .Qout_N748(qw[24]), .Qout_N749(qw[25]), .Qout_N750(qw[26]), .Qout_N751(qw[27]),
        .Qout_N752(qw[28]), .Qout_N753(qw[29]), .Qout_N754(qw[30]), .Qout_N755(qw[31]),
        .nn1(nnw[1]), .nn2(nnw[2]), .nn3(nnw[3]), .nn4(nnw[4]), .nn5(nnw[5]), .nn6(nnw[6]), .nn7(nnw[7]),
        .nn8(nnw[8]), .nn9(nnw[9]), .nn10(nnw[10]), .nn11(nnw[11]), .nn12(nnw[12]), .nn13(nnw[13]),
        .nn14(nnw[14]), .nn15(nnw[15]), .nn16(nnw[16]), .nn17(nnw[17]), .nn18(nnw[18]), .nn19(nnw[19]),
        .nn20(nnw[20]), .nn21(nnw[21]), .nn22(nnw[22]), .nn23(nnw[23]), .nn24(nnw[24]), .nn25(nnw[25]),
        .nn26(nnw[26]), .nn27(nnw[27]), .nn28(nnw[28]), .nn29(nnw[29]), .nn30(nnw[30]), .nn31(nnw[31]),
        .nn32(nnw[32]), .nn33(nnw[33]), .nn34(nnw[34]), .nn35(nnw[35]), .nn36(nnw[36]), .nn37(nnw[37]),
        .nn38(nnw[38]), .nn39(nnw[39]), .nn40(nnw[40]), .nn41(nnw[41]), .nn42(nnw[42]), .nn43(nnw[43]),
        .nn44(nnw[44]), .nn45(nnw[45]), .nn46(nnw[46]), .nn47(nnw[47]), .nn48(nnw[48]), .nn49(nnw[49]),
        .reset_n(reset_n)
    );

    // Syndrome written out as the parity equations of each check bit.
    function automatic logic [7:0] ref_syn(input logic [31:0] d, input logic [7:0] c, input logic r);
        logic [7:0] g, s;
        g = r ? c : 8'h00;
        s[0] = g[0] ^ (^d[23:16]) ^ d[0] ^ d[4] ^ d[8]  ^ d[12];
        s[1] = g[1] ^ (^d[31:24]) ^ d[1] ^ d[5] ^ d[9]  ^ d[13];
        s[2] = g[2] ^ (^d[19:16]) ^ (^d[27:24]) ^ d[2] ^ d[6] ^ d[10] ^ d[14];
        s[3] = g[3] ^ (^d[23:20]) ^ (^d[31:28]) ^ d[3] ^ d[7] ^ d[11] ^ d[15];
        s[4] = g[4] ^ (^d[7:0])   ^ d[16] ^ d[20] ^ d[24] ^ d[28];
        s[5] = g[5] ^ (^d[15:8])  ^ d[17] ^ d[21] ^ d[25] ^ d[29];
        s[6] = g[6] ^ (^d[3:0])   ^ (^d[11:8])  ^ d[18] ^ d[22] ^ d[26] ^ d[30];
        s[7] = g[7] ^ (^d[7:4])   ^ (^d[15:12]) ^ d[19] ^ d[23] ^ d[27] ^ d[31];
        return s;
    endfunction

    // Column of data bit k built from the index rule with integer arithmetic.
    function automatic logic [7:0] ref_col(input int k);
        int j, q, a, b, one;
        logic [7:0] m;
        j = k % 4;
        q = (k % 16) / 4;
        one = (k < 16) ? j : 4 + j;
        a = (k < 16) ? ((q < 2) ? 4 : 5) : ((q < 2) ? 0 : 1);
        b = (k < 16) ? ((q % 2 == 0) ? 6 : 7) : ((q % 2 == 0) ? 2 : 3);
        m = 8'h00;
        m[one] = 1'b1;
        m[a] = 1'b1;
        m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_flip(input logic [7:0] s);
        logic [31:0] f;
        f = 32'h0;
        for (int k = 0; k < 32; k++) f[k] = (s == ref_col(k));
        return f;
    endfunction

    function automatic logic [49:1] ref_nn(input logic [31:0] d, input logic [7:0] c, input logic r);
        logic [7:0] s;
        s = ref_syn(d, c, r);
        return {|s, (r ? c : 8'h00), ref_flip(s), s};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference pipeline: stage 1 holds inputs, stage 2 the corrected word.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_d <= '0; m_c <= '0; m_r <= 1'b0; m_q <= '0;
        end else begin
            m_q <= m_d ^ ref_flip(ref_syn(m_d, m_c, m_r));
            m_d <= td; m_c <= tc; m_r <= tr;
        end
    end

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_in", 64'({in_dw, in_cw, in_rw}), 64'({m_d, m_c, m_r}));
            check("cyc_nn", 64'(nnw), 64'(ref_nn(m_d, m_c, m_r)));
            check("cyc_qout", 64'(qw), 64'(m_q));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] d, input logic [7:0] c, input logic r);
        td = d; tc = c; tr = r;
    endtask

    task automatic check_all_zero(input string name);
        check(name, 64'({in_dw, in_cw, in_rw}), 64'h0);
        check({name, "_q"}, 64'(qw), 64'h0);
        check({name, "_nn"}, 64'(nnw), 64'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  c;
        int          mode, pos;

        reset_n = 1'b0;
        set_in($urandom, 8'($urandom), 1'b1);

        // Model anchors from hand-computed columns.
        check("model_col_d0", 64'(ref_syn(32'h1, 8'h00, 1'b1)), 64'h51);
        check("model_col_d16", 64'(ref_syn(32'h0001_0000, 8'h00, 1'b1)), 64'h15);

        repeat (3) tick();
        check_all_zero("rst");

        // Release: first capture on the next rising edge.
        reset_n = 1'b1;
        set_in(32'hA5C3_0F96, 8'h3C, 1'b1);
        chk_en = 1'b1;
        tick();
        check("first_capture", 64'({in_dw, in_cw, in_rw}), 64'({32'hA5C3_0F96, 8'h3C, 1'b1}));

        // All zero, R=1.
        set_in(32'h0, 8'h00, 1'b1);
        tick();
        check("zero_syn", 64'(nnw[8:1]), 64'h0);
        check("zero_nn49", 64'(nnw[49]), 64'h0);

        // Latency: valid codeword for d0 sampled at edge t.
        set_in(32'h1, 8'h51, 1'b1);
        tick();
        check("cw_syn", 64'(nnw[8:1]), 64'h0);
        check("lat_edge_t", 64'(qw), 64'h0);
        set_in(32'h1, 8'h00, 1'b1);
        tick();
        check("lat_edge_t1", 64'(qw), 64'h1);
        // N1 only: S0,S4,S6 set, f0 set.
        check("d0_nn1_5_7", 64'({nnw[1], nnw[5], nnw[7]}), 64'h7);
        check("d0_nn9", 64'(nnw[9]), 64'h1);
        set_in(32'h1, 8'h51, 1'b0);
        tick();
        check("d0_qout", 64'(qw), 64'h0);
        tick();
        check("cw_r0_qout", 64'(qw), 64'h0);

        // All 32 single-bit data errors.
        for (int k = 0; k < 32; k++) begin
            set_in(32'h1 << k, 8'h00, 1'b1);
            tick();
            check("single_flip", 64'(nnw[40:9]), 64'(32'h1 << k));
            if (k == 16) begin
                check("d16_syn", 64'(nnw[8:1]), 64'h15);
                check("d16_nn25", 64'(nnw[25]), 64'h1);
            end
            if (k > 0) check("single_qout", 64'(qw), 64'h0);
        end

        // Double error on check bits: no flip.
        set_in(32'h0, 8'h03, 1'b1);
        tick();
        check("single_qout_last", 64'(qw), 64'h0);
        check("dbl_syn", 64'(nnw[8:1]), 64'h03);
        check("dbl_nn49", 64'(nnw[49]), 64'h1);
        check("dbl_flip", 64'(nnw[40:9]), 64'h0);
        tick();
        check("dbl_qout", 64'(qw), 64'h0);

        // Randomized traffic, mixing arbitrary vectors, codewords and
        // codewords with one flipped bit.
        for (int n = 0; n < 600; n++) begin
            d = $urandom;
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                set_in(d, 8'($urandom), 1'($urandom));
            end else begin
                c = ref_syn(d, 8'h00, 1'b1);
                if (mode == 2) begin
                    pos = $urandom_range(0, 39);
                    if (pos < 32) d[pos] = ~d[pos];
                    else c[pos - 32] = ~c[pos - 32];
                end
                set_in(d, c, 1'b1);
            end
            if (n == 300) begin
                // Mid-stream asynchronous reset between edges.
                #2 reset_n = 1'b0;
                #1 check_all_zero("mid_rst");
                tick();
                reset_n = 1'b1;
            end else begin
                tick();
            end
        end

        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
